// File: rtl/householder_apply.sv
// householder_apply
//   Computes R = H*A for a 2x2 Householder reflector H and a 2x2 matrix A,
//   all Q8.8 signed. One signed 16x16 multiplier and a 33-bit accumulator
//   are time-shared over eight cycles. A small FSM (IDLE -> MAC -> DONE)
//   sequences the work, with valid/ready handshakes on both sides.
//
//   Optional feature macro: HOUSEHOLDER_APPLY_SAT_EN
//     defined   : results clamp to [0x8000, 0x7FFF] and O_sat reports clipping
//     undefined : results keep the low 16 bits (wrap) and O_sat is tied to 0
//
// Ports
//   I_sys_clk, I_sys_rst        clock (rising edge), async active-high reset
//   I_enable                    clock enable; low freezes every register
//   I_valid / O_ready           operand handshake (O_ready high only in IDLE)
//   I_h11..I_h22, I_a11..I_a22  operands, Q8.8 signed
//   O_valid / I_ready           result handshake (O_valid held until taken)
//   O_r11..O_r22                result R = H*A, Q8.8 signed
//   O_sat                       at least one result element was clipped
module householder_apply (
  input  logic        I_sys_clk,
  input  logic        I_sys_rst,
  input  logic        I_enable,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [15:0] I_h11,
  input  logic [15:0] I_h12,
  input  logic [15:0] I_h21,
  input  logic [15:0] I_h22,
  input  logic [15:0] I_a11,
  input  logic [15:0] I_a12,
  input  logic [15:0] I_a21,
  input  logic [15:0] I_a22,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [15:0] O_r11,
  output logic [15:0] O_r12,
  output logic [15:0] O_r21,
  output logic [15:0] O_r22,
  output logic        O_sat
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t             state_q;
  logic [2:0]         cnt_q;
  logic signed [32:0] acc_q;
  logic signed [15:0] h_q [0:3];   // h11, h12, h21, h22
  logic signed [15:0] a_q [0:3];   // a11, a12, a21, a22
  logic        [15:0] r_q [0:3];   // r11, r12, r21, r22
  logic               valid_q;
  logic               ready_q;

  // Product order for cnt = 0..7:
  //   H11*A11, H12*A21, H11*A12, H12*A22, H21*A11, H22*A21, H21*A12, H22*A22
  // cnt[2] picks the H row, cnt[0] the H column / A row, cnt[1] the A column.
  logic signed [15:0] h_sel_d;
  logic signed [15:0] a_sel_d;
  logic signed [31:0] prod_d;
  logic signed [32:0] sum_d;
  logic        [15:0] red_d;      // pair sum shifted right 8 and reduced to 16 bits

  always_comb begin
    h_sel_d = h_q[{cnt_q[2], cnt_q[0]}];
    a_sel_d = a_q[{cnt_q[0], cnt_q[1]}];
    prod_d  = h_sel_d * a_sel_d;
    sum_d   = acc_q + $signed({prod_d[31], prod_d});
  end

`ifdef HOUSEHOLDER_APPLY_SAT_EN
  logic signed [32:0] shifted_d;
  logic               clip_d;
  logic               sat_q;

  always_comb begin
    shifted_d = sum_d >>> 8;
    clip_d    = 1'b0;
    red_d     = shifted_d[15:0];
    if (shifted_d > 33'sd32767) begin
      red_d  = 16'h7FFF;
      clip_d = 1'b1;
    end else if (shifted_d < -33'sd32768) begin
      red_d  = 16'h8000;
      clip_d = 1'b1;
    end
  end

  assign O_sat = sat_q;
`else
  // Arithmetic shift by 8 then keep 16 bits is just a bit slice.
  assign red_d = sum_d[23:8];
  assign O_sat = 1'b0;
`endif

  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        h_q[i] <= '0;
        a_q[i] <= '0;
        r_q[i] <= '0;
      end
`ifdef HOUSEHOLDER_APPLY_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else if (I_enable) begin
      case (state_q)
        S_IDLE: begin
          if (I_valid && ready_q) begin
            h_q[0]  <= I_h11;
            h_q[1]  <= I_h12;
            h_q[2]  <= I_h21;
            h_q[3]  <= I_h22;
            a_q[0]  <= I_a11;
            a_q[1]  <= I_a12;
            a_q[2]  <= I_a21;
            a_q[3]  <= I_a22;
            cnt_q   <= 3'd0;
            acc_q   <= '0;
            ready_q <= 1'b0;
            state_q <= S_MAC;
`ifdef HOUSEHOLDER_APPLY_SAT_EN
            sat_q   <= 1'b0;
`endif
          end
        end
        S_MAC: begin
          if (cnt_q[0]) begin
            // Second product of a pair: retire the element, restart the sum.
            r_q[cnt_q[2:1]] <= red_d;
            acc_q           <= '0;
`ifdef HOUSEHOLDER_APPLY_SAT_EN
            sat_q           <= sat_q | clip_d;
`endif
          end else begin
            acc_q <= sum_d;
          end
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (I_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_ready = ready_q;
  assign O_valid = valid_q;
  assign O_r11   = r_q[0];
  assign O_r12   = r_q[1];
  assign O_r21   = r_q[2];
  assign O_r22   = r_q[3];

endmodule
